// File: rtl/sd_pkg.sv
// Shared constants and helpers for the sigma-delta CIC receive path.
package sd_pkg;

    localparam int SD_ACC_WIDTH = 32;
    localparam int CIC_ORDER    = 3;

    localparam logic signed [SD_ACC_WIDTH-1:0] SD_PLUS  = 32'sd1;
    localparam logic signed [SD_ACC_WIDTH-1:0] SD_MINUS = -32'sd1;

    // Clamp a 64-bit two's complement value into the signed 32-bit range.
    function automatic logic [31:0] sat32(input logic [63:0] value);
        if (value[63:31] == {33{value[63]}}) begin
            return value[31:0];
        end else if (value[63]) begin
            return 32'h8000_0000;
        end else begin
            return 32'h7FFF_FFFF;
        end
    endfunction

endpackage

// File: rtl/sd_cic_integrator.sv
// One wrapping accumulator stage of the CIC integrator chain.
module sd_cic_integrator
    import sd_pkg::*;
#(
    parameter int WIDTH = SD_ACC_WIDTH
) (
    input  logic             filter_clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc
);

    always_ff @(posedge filter_clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/sd_cic_decimator.sv
// Third-order CIC decimator turning a 1-bit sigma-delta stream into saturated
// 32-bit PCM words delivered over a valid/ready handshake.
module sd_cic_decimator
    import sd_pkg::*;
#(
    parameter int DECIM      = 64,
    parameter int LOG2_DECIM = 6,
    parameter int OUT_SHIFT  = 12
) (
    input  logic        filter_clock,
    input  logic        reset_n,
    input  logic        sd_in,
    input  logic        sd_valid,
    output logic [31:0] pcm_out,
    output logic        pcm_valid,
    input  logic        pcm_ready,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam logic [LOG2_DECIM-1:0] CNT_LAST = LOG2_DECIM'(DECIM - 1);

    logic [SD_ACC_WIDTH-1:0] stage [CIC_ORDER+1];
    logic [LOG2_DECIM-1:0]   cnt;
    logic                    dec_stb;
    logic [SD_ACC_WIDTH-1:0] d1, d2, d3;
    logic [SD_ACC_WIDTH-1:0] c1, c2, c3;
    logic [63:0]             scaled;
    logic [31:0]             new_sample;

    assign stage[0] = sd_in ? SD_PLUS : SD_MINUS;

    // Each stage adds the previous stage's registered value, so the chain is pipelined.
    for (genvar g = 0; g < CIC_ORDER; g++) begin : g_integ
        sd_cic_integrator #(
            .WIDTH(SD_ACC_WIDTH)
        ) u_integ (
            .filter_clock(filter_clock),
            .reset_n     (reset_n),
            .enable      (sd_valid),
            .din         (stage[g]),
            .acc         (stage[g+1])
        );
    end

    always_ff @(posedge filter_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= sd_valid && (cnt == CNT_LAST);
            if (sd_valid) begin
                cnt <= cnt + LOG2_DECIM'(1);
            end
        end
    end

    assign c1 = stage[CIC_ORDER] - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    // Sign-extend before shifting so large comb results saturate instead of wrapping.
    assign scaled     = {{32{c3[31]}}, c3} << OUT_SHIFT;
    assign new_sample = sat32(scaled);

    always_ff @(posedge filter_clock or negedge reset_n) begin
        if (!reset_n) begin
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else if (dec_stb) begin
            d1        <= stage[CIC_ORDER];
            d2        <= c1;
            d3        <= c2;
            pcm_out   <= new_sample;
            pcm_valid <= 1'b1;
        end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
        end
    end

    // Setting takes priority over a clear arriving in the same cycle.
    always_ff @(posedge filter_clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (dec_stb && pcm_valid && !pcm_ready) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Directed self-checking bench for sd_cic_decimator (default and saturating shift).
module tb_sd_cic_decimator;

    logic        clk;
    logic        reset_n;
    logic        sd_in;
    logic        sd_valid;
    logic        pcm_ready;
    logic        overrun_clr;
    logic [31:0] pcm_out, pcm_out_sat;
    logic        pcm_valid, pcm_valid_sat;
    logic        overrun, overrun_sat;

    int          total = 0;
    int          bad = 0;
    int          j = 0;
    int          ncyc = 0;
    bit          alt_in = 0;
    bit          alt_valid = 0;
    logic [31:0] q[$];
    logic [31:0] qs[$];
    int          qt[$];

    sd_cic_decimator dut (
        .filter_clock(clk),
        .reset_n     (reset_n),
        .sd_in       (sd_in),
        .sd_valid    (sd_valid),
        .pcm_out     (pcm_out),
        .pcm_valid   (pcm_valid),
        .pcm_ready   (pcm_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    sd_cic_decimator #(.OUT_SHIFT(14)) dut_sat (
        .filter_clock(clk),
        .reset_n     (reset_n),
        .sd_in       (sd_in),
        .sd_valid    (sd_valid),
        .pcm_out     (pcm_out_sat),
        .pcm_valid   (pcm_valid_sat),
        .pcm_ready   (pcm_ready),
        .overrun     (overrun_sat),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Record every accepted sample shortly after the falling edge.
    always @(negedge clk) begin
        #1;
        if (pcm_valid && pcm_ready) begin
            q.push_back(pcm_out);
            qt.push_back(ncyc);
        end
        if (pcm_valid_sat && pcm_ready) qs.push_back(pcm_out_sat);
    end

    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0; sd_in = 1'b0; sd_valid = 1'b0; pcm_ready = 1'b0;
        overrun_clr = 1'b0; alt_in = 1'b0; alt_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        j = 0;
        q.delete(); qs.delete(); qt.delete();
    endtask

    task automatic step_to(input int target);
        while (j < target) begin
            @(negedge clk);
            j++;
            if (alt_in) sd_in = ~sd_in;
            if (alt_valid) sd_valid = ~sd_valid;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1; sd_in = 1'b1; sd_valid = 1'b1; pcm_ready = 1'b0; overrun_clr = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++; if (pcm_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_pcm_out got %h want %h", pcm_out, 32'h0); end
        total++; if (pcm_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_pcm_valid got %b want 0", pcm_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
        total++; if (pcm_out_sat !== 32'h0) begin bad++; $display("[TB] FAIL reset_sat_out got %h want %h", pcm_out_sat, 32'h0); end
        total++; if (pcm_valid_sat !== 1'b0) begin bad++; $display("[TB] FAIL reset_sat_valid got %b want 0", pcm_valid_sat); end
    endtask

    task automatic test_const(input logic level, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] steady);
        do_reset();
        sd_in = level; sd_valid = 1'b1; pcm_ready = 1'b1;
        step_to(64 * 7 + 5);
        total++; if (q.size() !== 7) begin bad++; $display("[TB] FAIL const_count lvl=%b got %0d want 7", level, q.size()); end
        total++; if (q[0] !== s1) begin bad++; $display("[TB] FAIL const_s1 lvl=%b got %h want %h", level, q[0], s1); end
        total++; if (q[1] !== s2) begin bad++; $display("[TB] FAIL const_s2 lvl=%b got %h want %h", level, q[1], s2); end
        for (int i = 3; i < 7; i++) begin
            total++; if (q[i] !== steady) begin bad++; $display("[TB] FAIL const_steady lvl=%b idx=%0d got %h want %h", level, i, q[i], steady); end
        end
        total++; if (qt[5] - qt[4] !== 64) begin bad++; $display("[TB] FAIL const_spacing got %0d want 64", qt[5] - qt[4]); end
    endtask

    task automatic test_alternating;
        do_reset();
        sd_in = 1'b1; sd_valid = 1'b1; pcm_ready = 1'b1; alt_in = 1'b1;
        step_to(64 * 6 + 5);
        total++; if (q.size() !== 6) begin bad++; $display("[TB] FAIL alt_count got %0d want 6", q.size()); end
        for (int i = 3; i < 6; i++) begin
            total++; if (q[i] !== 32'h0) begin bad++; $display("[TB] FAIL alt_steady idx=%0d got %h want 0", i, q[i]); end
        end
    endtask

    task automatic test_latency(input bit toggle);
        int bits;
        int t64;
        int trise;
        do_reset();
        sd_in = 1'b1; sd_valid = 1'b1; pcm_ready = 1'b1;
        bits = 0; t64 = -1; trise = -1;
        for (int k = 0; k < 400 && trise < 0; k++) begin
            if (sd_valid) begin
                bits++;
                if (bits == 64) t64 = k;
            end
            if (pcm_valid) trise = k;
            @(negedge clk);
            if (toggle) sd_valid = ~sd_valid;
        end
        total++;
        if (trise < 0 || t64 < 0 || trise - t64 !== 2) begin
            bad++; $display("[TB] FAIL latency tog=%b got %0d want 2 (t64=%0d rise=%0d)", toggle, trise - t64, t64, trise);
        end
    endtask

    task automatic test_valid_gaps;
        do_reset();
        sd_in = 1'b1; sd_valid = 1'b1; pcm_ready = 1'b1; alt_valid = 1'b1;
        step_to(128 * 5 + 4);
        total++; if (q.size() !== 5) begin bad++; $display("[TB] FAIL gap_count got %0d want 5", q.size()); end
        total++; if (q[0] !== 32'h0A2C_0000) begin bad++; $display("[TB] FAIL gap_s1 got %h want %h", q[0], 32'h0A2C_0000); end
        total++; if (q[3] !== 32'h4000_0000) begin bad++; $display("[TB] FAIL gap_s4 got %h want %h", q[3], 32'h4000_0000); end
        total++; if (q[4] !== 32'h4000_0000) begin bad++; $display("[TB] FAIL gap_s5 got %h want %h", q[4], 32'h4000_0000); end
        total++; if (qt[4] - qt[3] !== 128) begin bad++; $display("[TB] FAIL gap_spacing got %0d want 128", qt[4] - qt[3]); end
    endtask

    task automatic test_overrun;
        do_reset();
        sd_in = 1'b1; sd_valid = 1'b1; pcm_ready = 1'b0;
        step_to(65);
        total++; if (pcm_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_first_valid got %b want 1", pcm_valid); end
        total++; if (pcm_out !== 32'h0A2C_0000) begin bad++; $display("[TB] FAIL ovr_first_out got %h want %h", pcm_out, 32'h0A2C_0000); end
        step_to(100);
        total++; if (pcm_out !== 32'h0A2C_0000) begin bad++; $display("[TB] FAIL ovr_hold_out got %h want %h", pcm_out, 32'h0A2C_0000); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_hold_flag got %b want 0", overrun); end
        step_to(129);
        total++; if (pcm_out !== 32'h34D4_0000) begin bad++; $display("[TB] FAIL ovr_overwrite got %h want %h", pcm_out, 32'h34D4_0000); end
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_set got %b want 1", overrun); end
        step_to(150);
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_sticky got %b want 1", overrun); end
        overrun_clr = 1'b1;
        step_to(151);
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_clear got %b want 0", overrun); end
        step_to(192);
        pcm_ready = 1'b1;
        step_to(193);
        total++; if (pcm_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_xfer_load_valid got %b want 1", pcm_valid); end
        total++; if (pcm_out !== 32'h4000_0000) begin bad++; $display("[TB] FAIL ovr_xfer_load_out got %h want %h", pcm_out, 32'h4000_0000); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_xfer_load_flag got %b want 0", overrun); end
        step_to(194);
        total++; if (pcm_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_consumed got %b want 0", pcm_valid); end
        step_to(257);
        pcm_ready = 1'b0;
        step_to(320);
        overrun_clr = 1'b1;
        step_to(321);
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_set_wins got %b want 1", overrun); end
    endtask

    task automatic test_saturation;
        do_reset();
        sd_in = 1'b1; sd_valid = 1'b1; pcm_ready = 1'b1;
        step_to(64 * 5 + 5);
        total++; if (qs.size() !== 5) begin bad++; $display("[TB] FAIL sat_count got %0d want 5", qs.size()); end
        total++; if (qs[3] !== 32'h7FFF_FFFF) begin bad++; $display("[TB] FAIL sat_pos got %h want %h", qs[3], 32'h7FFF_FFFF); end
        total++; if (qs[4] !== 32'h7FFF_FFFF) begin bad++; $display("[TB] FAIL sat_pos2 got %h want %h", qs[4], 32'h7FFF_FFFF); end
        do_reset();
        sd_in = 1'b0; sd_valid = 1'b1; pcm_ready = 1'b1;
        step_to(64 * 5 + 5);
        total++; if (qs[3] !== 32'h8000_0000) begin bad++; $display("[TB] FAIL sat_neg got %h want %h", qs[3], 32'h8000_0000); end
        total++; if (qs[4] !== 32'h8000_0000) begin bad++; $display("[TB] FAIL sat_neg2 got %h want %h", qs[4], 32'h8000_0000); end
    endtask

    task automatic test_async_reset;
        do_reset();
        sd_in = 1'b1; sd_valid = 1'b1; pcm_ready = 1'b0;
        step_to(140);
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL arst_pre_flag got %b want 1", overrun); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (pcm_out !== 32'h0) begin bad++; $display("[TB] FAIL arst_out got %h want 0", pcm_out); end
        total++; if (pcm_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_valid got %b want 0", pcm_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL arst_flag got %b want 0", overrun); end
        reset_n = 1'b1;
        j = 0;
        pcm_ready = 1'b1;
        q.delete(); qs.delete(); qt.delete();
        step_to(64 * 7 + 5);
        total++; if (q.size() !== 7) begin bad++; $display("[TB] FAIL arst_count got %0d want 7", q.size()); end
        total++; if (q[0] !== 32'h0A2C_0000) begin bad++; $display("[TB] FAIL arst_s1 got %h want %h", q[0], 32'h0A2C_0000); end
        total++; if (q[1] !== 32'h34D4_0000) begin bad++; $display("[TB] FAIL arst_s2 got %h want %h", q[1], 32'h34D4_0000); end
        total++; if (q[3] !== 32'h4000_0000) begin bad++; $display("[TB] FAIL arst_s4 got %h want %h", q[3], 32'h4000_0000); end
        total++; if (q[6] !== 32'h4000_0000) begin bad++; $display("[TB] FAIL arst_s7 got %h want %h", q[6], 32'h4000_0000); end
    endtask

    initial begin
        test_reset();
        test_const(1'b1, 32'h0A2C_0000, 32'h34D4_0000, 32'h4000_0000);
        test_const(1'b0, 32'hF5D4_0000, 32'hCB2C_0000, 32'hC000_0000);
        test_alternating();
        test_latency(1'b0);
        test_latency(1'b1);
        test_valid_gaps();
        test_overrun();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
